gon_axi_slave_mem: RTL and testbench

- AXI3 slave responder with an internal byte-enable memory; the counterpart of the AXI master agent, used as the memory-mapped target in block and top-level benches.
- Accepts INCR bursts on AW/W/B and AR/R with one outstanding transaction per direction; write and read channels are fully independent.

---
 rtl/gon_axi_pkg.sv | 34 +++
 rtl/gon_axi_slave_ram.sv | 28 ++
 rtl/gon_axi_slave_mem.sv | 204 ++++++++++++++++++++
 tb/tb_gon_axi_slave_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gon_axi_pkg.sv
// Shared AXI3 types for the gon AXI slave memory: response codes, burst lengths and FSM states.
package gon_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  // AXI3 LEN field values (beats minus one) for the common power-of-two bursts.
  typedef enum logic [3:0] {
    LEN_1  = 4'd0,
    LEN_2  = 4'd1,
    LEN_4  = 4'd3,
    LEN_8  = 4'd7,
    LEN_16 = 4'd15
  } burst_length_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/gon_axi_slave_ram.sv
// Simple dual-port RAM: byte-enable write port and registered, enable-gated read port.
module gon_axi_slave_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read and write share one block so a same-cycle collision returns the old word.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < STRB_W; i++) begin
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/gon_axi_slave_mem.sv
// AXI3 INCR-burst slave memory, one outstanding transaction per direction.
// Define GON_AXI_SLAVE_BACKPRESSURE_EN to throttle readys and read fetches with an LFSR.
module gon_axi_slave_mem
  import gon_axi_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int C_MEM_WORDS      = 256
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESET_N,
  input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [3:0]                    AXI_AWLEN,
  input  logic                          AXI_AWVALID,
  output logic                          AXI_AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                          AXI_WVALID,
  output logic                          AXI_WREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
  output logic [1:0]                    AXI_BRESP,
  output logic                          AXI_BVALID,
  input  logic                          AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [3:0]                    AXI_ARLEN,
  input  logic                          AXI_ARVALID,
  output logic                          AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]                    AXI_RRESP,
  output logic                          AXI_RLAST,
  output logic                          AXI_RVALID,
  input  logic                          AXI_RREADY,
  output wr_state_e                     dbg_wr_state,
  output rd_state_e                     dbg_rd_state
);

  localparam int BYTE_SHIFT = $clog2(C_AXI_DATA_WIDTH / 8);
  localparam int MEM_AW     = $clog2(C_MEM_WORDS);
  localparam logic [C_AXI_ADDR_WIDTH-1:0] MEM_LIMIT = C_AXI_ADDR_WIDTH'(C_MEM_WORDS);
  localparam logic [C_AXI_ADDR_WIDTH-1:0] IDX_ONE   = C_AXI_ADDR_WIDTH'(1);

  // Handshake rule: a transfer happens on a posedge where VALID and READY are both 1;
  // a VALID this slave raises stays high, payload stable, until that transfer.

  wr_state_e                     w_state;
  rd_state_e                     r_state;
  logic [C_AXI_ADDR_WIDTH-1:0]   w_idx, r_idx;
  logic [3:0]                    w_len, w_cnt, r_len, r_cnt;
  logic                          w_err, w_oor, r_oor;
  logic                          ram_we, ram_re;
  logic [C_AXI_DATA_WIDTH-1:0]   ram_rdata;
  logic                          rdy_gate, fetch_go;

`ifdef GON_AXI_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESET_N) lfsr <= LFSR_SEED;
    else               lfsr <= lfsr_nxt;
  end
  // Readys are registered, so gate them with the LFSR value they will coexist with.
  assign rdy_gate = lfsr_nxt[0];
  assign fetch_go = lfsr[1];
`else
  assign rdy_gate = 1'b1;
  assign fetch_go = 1'b1;
`endif

  assign w_oor  = (w_idx >= MEM_LIMIT);
  assign r_oor  = (r_idx >= MEM_LIMIT);
  assign ram_we = (w_state == W_DATA) && AXI_WVALID && AXI_WREADY && !w_oor;
  assign ram_re = (r_state == R_FETCH);

  gon_axi_slave_ram #(
    .DATA_W (C_AXI_DATA_WIDTH),
    .DEPTH  (C_MEM_WORDS)
  ) u_ram (
    .clk   (AXI_ACLK),
    .we    (ram_we),
    .waddr (w_idx[MEM_AW-1:0]),
    .wdata (AXI_WDATA),
    .wstrb (AXI_WSTRB),
    .re    (ram_re),
    .raddr (r_idx[MEM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM only reads in R_FETCH, so RDATA holds while R_DATA waits on RREADY.
  assign AXI_RDATA    = (AXI_RVALID && AXI_RRESP != SLVERR) ? ram_rdata : '0;
  assign dbg_wr_state = w_state;
  assign dbg_rd_state = r_state;

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESET_N) begin
      w_state     <= W_IDLE;
      AXI_AWREADY <= 1'b0;
      AXI_WREADY  <= 1'b0;
      AXI_BVALID  <= 1'b0;
      AXI_BRESP   <= OKAY;
      AXI_BID     <= '0;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          AXI_AWREADY <= rdy_gate;
          if (AXI_AWVALID && AXI_AWREADY) begin
            AXI_AWREADY <= 1'b0;
            AXI_WREADY  <= rdy_gate;
            AXI_BID     <= AXI_AWID;
            w_idx       <= AXI_AWADDR >> BYTE_SHIFT;
            w_len       <= AXI_AWLEN;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          AXI_WREADY <= rdy_gate;
          if (AXI_WVALID && AXI_WREADY) begin
            if (w_cnt == w_len) begin
              AXI_WREADY <= 1'b0;
              AXI_BVALID <= 1'b1;
              AXI_BRESP  <= (w_err || w_oor) ? SLVERR : OKAY;
              w_state    <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 4'd1;
              w_idx <= w_idx + IDX_ONE;
              w_err <= w_err | w_oor;
            end
          end
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            AXI_BVALID  <= 1'b0;
            AXI_BRESP   <= OKAY;
            AXI_AWREADY <= rdy_gate;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESET_N) begin
      r_state     <= R_IDLE;
      AXI_ARREADY <= 1'b0;
      AXI_RVALID  <= 1'b0;
      AXI_RRESP   <= OKAY;
      AXI_RLAST   <= 1'b0;
      AXI_RID     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          AXI_ARREADY <= rdy_gate;
          if (AXI_ARVALID && AXI_ARREADY) begin
            AXI_ARREADY <= 1'b0;
            AXI_RID     <= AXI_ARID;
            r_idx       <= AXI_ARADDR >> BYTE_SHIFT;
            r_len       <= AXI_ARLEN;
            r_cnt       <= '0;
            r_state     <= R_FETCH;
          end
        end
        R_FETCH: begin
          if (fetch_go) begin
            AXI_RVALID <= 1'b1;
            AXI_RRESP  <= r_oor ? SLVERR : OKAY;
            AXI_RLAST  <= (r_cnt == r_len);
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (AXI_RREADY) begin
            AXI_RVALID <= 1'b0;
            AXI_RRESP  <= OKAY;
            AXI_RLAST  <= 1'b0;
            if (r_cnt == r_len) begin
              AXI_ARREADY <= rdy_gate;
              r_state     <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_idx   <= r_idx + IDX_ONE;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gon_axi_slave_mem.sv
// Directed bench for gon_axi_slave_mem: bursts, byte strobes, out-of-range beats, R stall, mid-burst reset.
module tb_gon_axi_slave_mem;
  import gon_axi_pkg::*;

  localparam int ID_W   = 1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int TMO    = 50;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [ID_W-1:0]   awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0]        awlen, arlen;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready, rlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [1:0]        bresp, rresp;
  wr_state_e         dbg_wr_state;
  rd_state_e         dbg_rd_state;

  gon_axi_slave_mem dut (
    .AXI_ACLK     (clk),
    .AXI_ARESET_N (rst_n),
    .AXI_AWID     (awid),
    .AXI_AWADDR   (awaddr),
    .AXI_AWLEN    (awlen),
    .AXI_AWVALID  (awvalid),
    .AXI_AWREADY  (awready),
    .AXI_WDATA    (wdata),
    .AXI_WSTRB    (wstrb),
    .AXI_WVALID   (wvalid),
    .AXI_WREADY   (wready),
    .AXI_BID      (bid),
    .AXI_BRESP    (bresp),
    .AXI_BVALID   (bvalid),
    .AXI_BREADY   (bready),
    .AXI_ARID     (arid),
    .AXI_ARADDR   (araddr),
    .AXI_ARLEN    (arlen),
    .AXI_ARVALID  (arvalid),
    .AXI_ARREADY  (arready),
    .AXI_RID      (rid),
    .AXI_RDATA    (rdata),
    .AXI_RRESP    (rresp),
    .AXI_RLAST    (rlast),
    .AXI_RVALID   (rvalid),
    .AXI_RREADY   (rready),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_resp_q[$];
  logic [DATA_W-1:0] wdata_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_outs();
    return {awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rlast, rid};
  endfunction

  // driver tasks
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                           input logic [ID_W-1:0] id, input logic [STRB_W-1:0] strb,
                           input logic [1:0] exp_resp, input string tag);
    int t;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    check({tag, "_awready"}, 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wdata_q.pop_front(); wstrb = strb; wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      check({tag, "_wready"}, 64'(wready), 64'd1);
      @(posedge clk); #1 wvalid = 1'b0;
    end
    bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    check({tag, "_bid"}, 64'(bid), 64'(id));
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                          input logic [ID_W-1:0] id, input int hold, input string tag);
    int t;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    check({tag, "_arready"}, 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    check({tag, "_lat_fetch"}, 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_lat_valid"}, 64'(rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      @(negedge clk);
      while (!rvalid && t < TMO) begin @(negedge clk); t++; end
      check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
      if (i == 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check({tag, "_hold_rvalid"}, 64'(rvalid), 64'd1);
          check({tag, "_hold_rdata"}, rdata, exp_q[0]);
          check({tag, "_hold_rid"}, 64'(rid), 64'(id));
        end
      end
      check({tag, "_rdata"}, rdata, exp_q.pop_front());
      check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp_q.pop_front()));
      check({tag, "_rlast"}, 64'(rlast), 64'(i == int'(len)));
      check({tag, "_rid"}, 64'(rid), 64'(id));
      rready = 1'b1;
      @(posedge clk); #1 rready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'(ctrl_outs()), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // 4-beat burst write then read back
    wdata_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    axi_write(32'h40, 4'd3, 1'b1, 8'hFF, OKAY, "t1w");
    exp_q      = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    exp_resp_q = '{OKAY, OKAY, OKAY, OKAY};
    axi_read(32'h40, 4'd3, 1'b1, 0, "t1r");

    // partial strobe over an all-ones word
    wdata_q = '{64'hFFFF_FFFF_FFFF_FFFF};
    axi_write(32'h100, 4'd0, 1'b0, 8'hFF, OKAY, "t2w_full");
    wdata_q = '{64'h0};
    axi_write(32'h100, 4'd0, 1'b0, 8'h0F, OKAY, "t2w_strb");
    exp_q      = '{64'hFFFF_FFFF_0000_0000};
    exp_resp_q = '{OKAY};
    axi_read(32'h100, 4'd0, 1'b0, 0, "t2r");

    // burst crossing the top of memory
    wdata_q = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
    axi_write(32'h7F0, 4'd3, 1'b1, 8'hFF, SLVERR, "t3w");
    exp_q      = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1, 64'h0, 64'h0};
    exp_resp_q = '{OKAY, OKAY, SLVERR, SLVERR};
    axi_read(32'h7F0, 4'd3, 1'b1, 0, "t3r");

    // R channel stalled by RREADY low
    exp_q      = '{64'h1111_1111_1111_1111};
    exp_resp_q = '{OKAY};
    axi_read(32'h40, 4'd0, 1'b1, 5, "t4r");

    // reset in the middle of a read burst
    arid = 1'b1; araddr = 32'h40; arlen = 4'd3; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    check("t5_arready", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(posedge clk); #1;
    check("t5_rvalid_before_rst", 64'(rvalid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_ctrl", 64'(ctrl_outs()), 64'd0);
    check("t5_rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_post_rst_arready", 64'(arready), 64'd1);
    exp_q      = '{64'hFFFF_FFFF_0000_0000};
    exp_resp_q = '{OKAY};
    axi_read(32'h100, 4'd0, 1'b0, 0, "t5r");

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
